hall_speed_meter: RTL

- Multi-channel hall-sensor speed and direction meter for the motor-control datapath; one instance serves all BLDC motors on the board.
- Per channel: synchronises the 3-bit hall code, decodes valid commutation steps and direction, and counts steps over a fixed gate window.
- At the end of each window, latches per-channel counts, direction and error flags, then pulses count_valid.
- Feeds the speed PID and telemetry blocks.

---
 rtl/hall_speed_meter_if.sv | 33 +++
 rtl/hall_speed_meter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_speed_meter_if.sv
// Bus bundle for the hall speed meter: raw hall codes and window restart in,
// latched per-channel speed/direction/error results out.
interface hall_speed_meter_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
);
   logic [3*NUM_CH-1:0]     hall;
   logic                    win_restart;
   logic [CNT_W*NUM_CH-1:0] count;
   logic [NUM_CH-1:0]       dir;
   logic [NUM_CH-1:0]       err;
   logic                    count_valid;

   // Driver side: supplies hall codes and restart, consumes results.
   modport master (
      output hall,
      output win_restart,
      input  count,
      input  dir,
      input  err,
      input  count_valid
   );

   // Meter side.
   modport slave (
      input  hall,
      input  win_restart,
      output count,
      output dir,
      output err,
      output count_valid
   );
endinterface

// File: rtl/hall_speed_meter.sv
// Multi-channel hall-sensor speed and direction meter.
// Each channel synchronises its 3-bit hall code, classifies every change as a
// forward step, reverse step or error, and counts steps inside a shared gate
// window. At the end of each window the live results are latched and
// count_valid pulses for one cycle.
module hall_speed_meter #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 8,
   parameter int GATE_CYCLES = 3163478,
   parameter int SYNC_STAGES = 2
) (
   input logic               inclk,
   input logic               rst_n,
   hall_speed_meter_if.slave bus
);
   localparam int               GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int               FILL_W    = $clog2(SYNC_STAGES + 1);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [2:0]        IDX_BAD   = 3'd7;

   // Position of a code in the forward commutation sequence; IDX_BAD for 000/111.
   function automatic logic [2:0] code_to_idx(input logic [2:0] code);
      logic [2:0] idx;
      case (code)
         3'b101:  idx = 3'd0;
         3'b100:  idx = 3'd1;
         3'b110:  idx = 3'd2;
         3'b010:  idx = 3'd3;
         3'b011:  idx = 3'd4;
         3'b001:  idx = 3'd5;
         default: idx = IDX_BAD;
      endcase
      return idx;
   endfunction

   function automatic logic [2:0] idx_inc(input logic [2:0] idx);
      return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
   endfunction

   function automatic logic [2:0] idx_dec(input logic [2:0] idx);
      return (idx == 3'd0) ? 3'd5 : idx - 3'd1;
   endfunction

   logic [3*NUM_CH-1:0] sync_q [SYNC_STAGES];
   logic [3*NUM_CH-1:0] code_w;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic                sync_full_w;
   logic [GATE_W-1:0]   gate_q, gate_d;
   logic                end_win_w;
   logic                restart_w;
   logic                count_valid_q, count_valid_d;
   logic [CNT_W-1:0]    cnt_ch_w [NUM_CH];
   logic                dir_ch_w [NUM_CH];
   logic                err_ch_w [NUM_CH];

   // Synchroniser chain, one register stage per generate iteration.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         // Shift the raw hall bus one stage further into the clock domain.
         always_ff @(posedge inclk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q[gi] <= '0;
            end else if (gi == 0) begin
               sync_q[gi] <= bus.hall;
            end else begin
               sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi - 1];
            end
         end
      end
   endgenerate

   assign code_w      = sync_q[SYNC_STAGES-1];
   assign sync_full_w = (fill_q == FILL_FULL);
   assign end_win_w   = (gate_q == GATE_LAST);
   assign restart_w   = bus.win_restart;

   // Shared control: synchroniser fill tracking, gate counter, result strobe.
   always_comb begin
      fill_d        = fill_q;
      gate_d        = gate_q + GATE_W'(1);
      count_valid_d = 1'b0;
      if (!sync_full_w) begin
         fill_d = fill_q + FILL_W'(1);
      end
      if (restart_w) begin
         gate_d = '0;
      end else if (end_win_w) begin
         gate_d        = '0;
         count_valid_d = 1'b1;
      end
   end

   // Shared control registers.
   always_ff @(posedge inclk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q        <= '0;
         gate_q        <= '0;
         count_valid_q <= 1'b0;
      end else begin
         fill_q        <= fill_d;
         gate_q        <= gate_d;
         count_valid_q <= count_valid_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [2:0]       code_c;
         logic [2:0]       idx_cur, idx_prev;
         logic [2:0]       prev_q, prev_d;
         logic             primed_q, primed_d;
         logic             step_w, fwd_w, bad_w;
         logic [CNT_W-1:0] live_cnt_q, live_cnt_d;
         logic             live_dir_q, live_dir_d;
         logic             live_err_q, live_err_d;
         logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
         logic             dir_out_q, dir_out_d;
         logic             err_out_q, err_out_d;

         assign code_c   = code_w[3*gi +: 3];
         assign idx_cur  = code_to_idx(code_c);
         assign idx_prev = code_to_idx(prev_q);

         // Classify this cycle's code against the previous legal code.
         always_comb begin
            step_w   = 1'b0;
            fwd_w    = 1'b0;
            bad_w    = 1'b0;
            prev_d   = prev_q;
            primed_d = primed_q;
            if (!primed_q) begin
               // First valid sample only seeds the reference; nothing counted.
               if (sync_full_w) begin
                  prev_d   = code_c;
                  primed_d = 1'b1;
               end
            end else if (idx_cur == IDX_BAD) begin
               bad_w = 1'b1;
            end else if (code_c != prev_q) begin
               prev_d = code_c;
               if (idx_prev == IDX_BAD) begin
                  // Reference seeded from an illegal code: cannot judge a step.
                  bad_w = 1'b1;
               end else if (idx_cur == idx_inc(idx_prev)) begin
                  step_w = 1'b1;
                  fwd_w  = 1'b1;
               end else if (idx_cur == idx_dec(idx_prev)) begin
                  step_w = 1'b1;
               end else begin
                  bad_w = 1'b1;
               end
            end
         end

         // Live window accumulation and end-of-window latching.
         always_comb begin
            live_cnt_d = live_cnt_q;
            live_dir_d = live_dir_q;
            live_err_d = live_err_q;
            cnt_out_d  = cnt_out_q;
            dir_out_d  = dir_out_q;
            err_out_d  = err_out_q;
            if (restart_w) begin
               // Abort: window contents and this cycle's step are dropped.
               live_cnt_d = '0;
               live_err_d = 1'b0;
            end else if (end_win_w) begin
               cnt_out_d = live_cnt_q;
               err_out_d = live_err_q;
               if (live_cnt_q != '0) begin
                  dir_out_d = live_dir_q;
               end
               // A step on the closing cycle opens the next window.
               live_cnt_d = step_w ? CNT_ONE : '0;
               live_err_d = bad_w | (step_w & (CNT_ONE == CNT_MAX));
               if (step_w) begin
                  live_dir_d = fwd_w;
               end
            end else begin
               if (step_w) begin
                  live_dir_d = fwd_w;
                  if (live_cnt_q == CNT_MAX) begin
                     live_err_d = 1'b1;
                  end else begin
                     live_cnt_d = live_cnt_q + CNT_ONE;
                     if (live_cnt_q + CNT_ONE == CNT_MAX) begin
                        live_err_d = 1'b1;
                     end
                  end
               end
               if (bad_w) begin
                  live_err_d = 1'b1;
               end
            end
         end

         // Per-channel state registers.
         always_ff @(posedge inclk or negedge rst_n) begin
            if (!rst_n) begin
               prev_q     <= 3'b000;
               primed_q   <= 1'b0;
               live_cnt_q <= '0;
               live_dir_q <= 1'b0;
               live_err_q <= 1'b0;
               cnt_out_q  <= '0;
               dir_out_q  <= 1'b0;
               err_out_q  <= 1'b0;
            end else begin
               prev_q     <= prev_d;
               primed_q   <= primed_d;
               live_cnt_q <= live_cnt_d;
               live_dir_q <= live_dir_d;
               live_err_q <= live_err_d;
               cnt_out_q  <= cnt_out_d;
               dir_out_q  <= dir_out_d;
               err_out_q  <= err_out_d;
            end
         end

         assign cnt_ch_w[gi] = cnt_out_q;
         assign dir_ch_w[gi] = dir_out_q;
         assign err_ch_w[gi] = err_out_q;
      end
   endgenerate

   // Pack registered per-channel results onto the output bus.
   always_comb begin
      bus.count = '0;
      bus.dir   = '0;
      bus.err   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         bus.count[CNT_W*c +: CNT_W] = cnt_ch_w[c];
         bus.dir[c]                  = dir_ch_w[c];
         bus.err[c]                  = err_ch_w[c];
      end
   end

   assign bus.count_valid = count_valid_q;
endmodule
